// File: rtl/sa_cache_pkg.sv
// rtl/sa_cache_pkg.sv - shared constants and helpers for the set-associative cache
// Contents:
//   WAYS, TAG_BITS, LINE_SIZE_BYTES, OFFSET_BITS, DATA_WIDTH : default geometry
//   LINE_SIZE_BITS, WAY_IDX_BITS                              : derived widths
//   MAX_WAYS                                                  : widest mask hit_way_encode accepts
//   hit_way_encode()                                          : hit mask -> highest set index
package sa_cache_pkg;

  localparam int WAYS            = 4;
  localparam int TAG_BITS        = 18;
  localparam int LINE_SIZE_BYTES = 64;
  localparam int OFFSET_BITS     = 6;
  localparam int DATA_WIDTH      = 32;

  localparam int LINE_SIZE_BITS  = 8 * LINE_SIZE_BYTES;
  localparam int WAY_IDX_BITS    = $clog2(WAYS);

  localparam int MAX_WAYS        = 64;

  // Later ways overwrite earlier ones, so the highest set bit wins; an
  // empty mask encodes to 0.
  function automatic int hit_way_encode(input logic [MAX_WAYS-1:0] hit);
    int idx;
    idx = 0;
    for (int w = 0; w < MAX_WAYS; w++) begin
      if (hit[w]) idx = w;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sa_tag_match.sv
// rtl/sa_tag_match.sv - per-way tag compare qualified by the way's valid bit
// Ports:
//   tag_a  in  TAG_BITS  lookup tag
//   tag_b  in  TAG_BITS  stored tag of this way
//   valid  in  1         valid bit of this way
//   match  out 1         tags equal and way valid
module sa_tag_match
  import sa_cache_pkg::*;
#(
  parameter int TAG_BITS = sa_cache_pkg::TAG_BITS
) (
  input  logic [TAG_BITS-1:0] tag_a,
  input  logic [TAG_BITS-1:0] tag_b,
  input  logic                valid,
  output logic                match
);

  assign match = (tag_a == tag_b) & valid;

endmodule

// File: rtl/sa_way_hit_select.sv
// rtl/sa_way_hit_select.sv - tag match, one-hot line select and word extract with one output register stage
// Optional feature macro: SA_WAY_HIT_SELECT_MULTIHIT_CHECK_EN (multi-hit detector; o_multi_hit tied 0 without it)
// Ports:
//   clk, rst (sync, active-high)
//   i_lookup     lookup strobe; inputs sampled when high
//   i_tag        lookup tag
//   i_offset     byte offset within the line
//   i_way_tags   stored tags, way w at [w*TAG_BITS +: TAG_BITS]
//   i_way_valid  valid bit per way
//   i_way_lines  line data, way w at [w*LINE_SIZE_BITS +: LINE_SIZE_BITS]
//   o_valid      registered i_lookup
//   o_hit        any way matched
//   o_hit_mask   per-way qualified match
//   o_hit_way    highest matching way, 0 on miss
//   o_line       OR of the matching lines, 0 on miss
//   o_data       DATA_WIDTH word at i_offset, bytes past the line end read 0
//   o_multi_hit  more than one way matched
module sa_way_hit_select
  import sa_cache_pkg::*;
#(
  parameter int WAYS            = sa_cache_pkg::WAYS,
  parameter int TAG_BITS        = sa_cache_pkg::TAG_BITS,
  parameter int LINE_SIZE_BYTES = sa_cache_pkg::LINE_SIZE_BYTES,
  parameter int OFFSET_BITS     = sa_cache_pkg::OFFSET_BITS,
  parameter int DATA_WIDTH      = sa_cache_pkg::DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_lookup,
  input  logic [TAG_BITS-1:0]                   i_tag,
  input  logic [OFFSET_BITS-1:0]                i_offset,
  input  logic [WAYS*TAG_BITS-1:0]              i_way_tags,
  input  logic [WAYS-1:0]                       i_way_valid,
  input  logic [WAYS*(8*LINE_SIZE_BYTES)-1:0]   i_way_lines,
  output logic                                  o_valid,
  output logic                                  o_hit,
  output logic [WAYS-1:0]                       o_hit_mask,
  output logic [$clog2(WAYS)-1:0]               o_hit_way,
  output logic [8*LINE_SIZE_BYTES-1:0]          o_line,
  output logic [DATA_WIDTH-1:0]                 o_data,
  output logic                                  o_multi_hit
);

  localparam int LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES;
  localparam int WAY_IDX_BITS   = $clog2(WAYS);
  // The line is padded with one word of zeros above its top so an offset
  // near the end can read a full word and get 0 for the missing bytes.
  localparam int EXT_BITS       = LINE_SIZE_BITS + DATA_WIDTH;
  localparam int BIT_IDX_BITS   = $clog2(EXT_BITS);

  logic [WAYS-1:0]           hit;
  logic [LINE_SIZE_BITS-1:0] sel_line;
  logic [EXT_BITS-1:0]       ext_line;
  logic [BIT_IDX_BITS-1:0]   bit_idx;
  logic [DATA_WIDTH-1:0]     data_word;
  logic [WAY_IDX_BITS-1:0]   hit_way;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    sa_tag_match #(
      .TAG_BITS (TAG_BITS)
    ) u_tag_match (
      .tag_a (i_tag),
      .tag_b (i_way_tags[w*TAG_BITS +: TAG_BITS]),
      .valid (i_way_valid[w]),
      .match (hit[w])
    );
  end

  // AND-OR mux: multiple hits OR their lines together on purpose.
  always_comb begin
    sel_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      sel_line = sel_line | ({LINE_SIZE_BITS{hit[w]}} & i_way_lines[w*LINE_SIZE_BITS +: LINE_SIZE_BITS]);
    end
  end

  assign ext_line  = {{DATA_WIDTH{1'b0}}, sel_line};
  assign bit_idx   = BIT_IDX_BITS'({i_offset, 3'b000});
  assign data_word = ext_line[bit_idx +: DATA_WIDTH];
  assign hit_way   = WAY_IDX_BITS'(hit_way_encode(MAX_WAYS'(hit)));

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_hit      <= 1'b0;
      o_hit_mask <= '0;
      o_hit_way  <= '0;
      o_line     <= '0;
      o_data     <= '0;
    end else begin
      o_valid <= i_lookup;
      if (i_lookup) begin
        o_hit      <= |hit;
        o_hit_mask <= hit;
        o_hit_way  <= hit_way;
        o_line     <= sel_line;
        o_data     <= data_word;
      end
    end
  end

`ifdef SA_WAY_HIT_SELECT_MULTIHIT_CHECK_EN
  logic multi_hit_d;
  assign multi_hit_d = ($countones(hit) > 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_multi_hit <= 1'b0;
    end else if (i_lookup) begin
      o_multi_hit <= multi_hit_d;
    end
  end
`else
  assign o_multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sa_way_hit_select.sv
// tb/tb_sa_way_hit_select.sv - scoreboard bench for sa_way_hit_select
module tb_sa_way_hit_select;

  localparam int W  = 4;
  localparam int TB = 18;
  localparam int LB = 512;
  localparam int DW = 32;
  localparam int OB = 6;

  typedef struct packed {
    logic          hit;
    logic [W-1:0]  mask;
    logic [1:0]    way;
    logic          multi;
    logic [DW-1:0] data;
    logic [LB-1:0] line;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_lookup = 1'b0;
  logic [TB-1:0]   i_tag = '0;
  logic [OB-1:0]   i_offset = '0;
  logic [W*TB-1:0] i_way_tags = '0;
  logic [W-1:0]    i_way_valid = '0;
  logic [W*LB-1:0] i_way_lines = '0;
  logic            o_valid;
  logic            o_hit;
  logic [W-1:0]    o_hit_mask;
  logic [1:0]      o_hit_way;
  logic [LB-1:0]   o_line;
  logic [DW-1:0]   o_data;
  logic            o_multi_hit;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  sa_way_hit_select dut (
    .clk         (clk),
    .rst         (rst),
    .i_lookup    (i_lookup),
    .i_tag       (i_tag),
    .i_offset    (i_offset),
    .i_way_tags  (i_way_tags),
    .i_way_valid (i_way_valid),
    .i_way_lines (i_way_lines),
    .o_valid     (o_valid),
    .o_hit       (o_hit),
    .o_hit_mask  (o_hit_mask),
    .o_hit_way   (o_hit_way),
    .o_line      (o_line),
    .o_data      (o_data),
    .o_multi_hit (o_multi_hit)
  );

  always #5 clk = ~clk;

  // Reference: per-way compare, OR of matching lines, byte-by-byte word build.
  function automatic exp_t model();
    exp_t e;
    int   cnt;
    int   idx;
    e   = '0;
    cnt = 0;
    for (int w = 0; w < W; w++) begin
      if (i_way_valid[w] && (i_way_tags[w*TB +: TB] == i_tag)) begin
        e.mask[w] = 1'b1;
        e.way     = 2'(w);
        e.line    = e.line | i_way_lines[w*LB +: LB];
        cnt++;
      end
    end
    e.hit = (cnt > 0);
`ifdef SA_WAY_HIT_SELECT_MULTIHIT_CHECK_EN
    e.multi = (cnt > 1);
`else
    e.multi = 1'b0;
`endif
    for (int b = 0; b < DW/8; b++) begin
      idx = int'(i_offset) + b;
      if (idx < LB/8) e.data[b*8 +: 8] = e.line[idx*8 +: 8];
    end
    return e;
  endfunction

  function automatic exp_t observed();
    return {o_hit, o_hit_mask, o_hit_way, o_multi_hit, o_data, o_line};
  endfunction

  task automatic random_lines();
    for (int i = 0; i < W*LB/32; i++) i_way_lines[i*32 +: 32] = $urandom();
  endtask

  task automatic distinct_tags();
    for (int w = 0; w < W; w++) i_way_tags[w*TB +: TB] = 18'h30000 + TB'(w);
  endtask

  task automatic push_lookup();
    i_lookup = 1'b1;
    exp_q.push_back(model());
  endtask

  task automatic test_reset();
    exp_t g;
    @(negedge clk);
    rst = 1'b1;
    i_tag = 18'h155;
    distinct_tags();
    i_way_tags[2*TB +: TB] = 18'h155;
    i_way_valid = 4'b1111;
    random_lines();
    i_lookup = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      g = observed();
      checks++;
      if (o_valid !== 1'b0 || g !== '0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got valid=%b hit=%b mask=%b way=%0d multi=%b data=%h, required all 0",
                 c, o_valid, g.hit, g.mask, g.way, g.multi, g.data);
      end
    end
    rst = 1'b0;
    i_lookup = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || observed() !== '0) begin
      errors++;
      $display("FAIL reset_release: got valid=%b hit=%b, required valid=0 hit=0", o_valid, o_hit);
    end
  endtask

  task automatic test_single_hit();
    exp_t e, g;
    @(negedge clk);
    random_lines();
    distinct_tags();
    i_way_tags[2*TB +: TB] = 18'h155;
    i_way_valid = 4'b1111;
    for (int k = 0; k < 64; k++) i_way_lines[2*LB + k*8 +: 8] = 8'(k);
    i_tag = 18'h155;
    i_offset = 6'd4;
    push_lookup();
    @(negedge clk);
    i_lookup = 1'b0;
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_hit o_valid: got %b required 1", o_valid);
    end
    e = exp_q.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL single_hit result: got hit=%b mask=%b way=%0d multi=%b data=%h line=%h required hit=%b mask=%b way=%0d multi=%b data=%h line=%h",
               g.hit, g.mask, g.way, g.multi, g.data, g.line, e.hit, e.mask, e.way, e.multi, e.data, e.line);
    end
    checks++;
    if (o_data !== 32'h07060504 || o_hit_mask !== 4'b0100 || o_hit_way !== 2'd2 || o_hit !== 1'b1) begin
      errors++;
      $display("FAIL single_hit fixed: got data=%h mask=%b way=%0d hit=%b required data=07060504 mask=0100 way=2 hit=1",
               o_data, o_hit_mask, o_hit_way, o_hit);
    end
  endtask

  task automatic test_invalid_match();
    exp_t e, g;
    @(negedge clk);
    random_lines();
    distinct_tags();
    i_way_tags[1*TB +: TB] = 18'h0ABC;
    i_tag = 18'h0ABC;
    i_way_valid = 4'b1101;
    i_offset = 6'd8;
    push_lookup();
    @(negedge clk);
    i_lookup = 1'b0;
    e = exp_q.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL invalid_match result: got hit=%b mask=%b way=%0d data=%h line=%h required hit=%b mask=%b way=%0d data=%h line=%h",
               g.hit, g.mask, g.way, g.data, g.line, e.hit, e.mask, e.way, e.data, e.line);
    end
    checks++;
    if (o_hit !== 1'b0 || o_hit_mask !== 4'b0 || o_line !== '0 || o_data !== '0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL invalid_match fixed: got valid=%b hit=%b mask=%b data=%h required valid=1 hit=0 mask=0000 data=0",
               o_valid, o_hit, o_hit_mask, o_data);
    end
  endtask

  task automatic test_end_offset();
    exp_t e, g;
    logic [LB-1:0] l0;
    @(negedge clk);
    random_lines();
    distinct_tags();
    i_way_tags[0 +: TB] = 18'h2AA;
    i_tag = 18'h2AA;
    i_way_valid = 4'b1111;
    i_offset = 6'd62;
    l0 = i_way_lines[0 +: LB];
    push_lookup();
    @(negedge clk);
    i_lookup = 1'b0;
    e = exp_q.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL end_offset result: got hit=%b way=%0d data=%h required hit=%b way=%0d data=%h",
               g.hit, g.way, g.data, e.hit, e.way, e.data);
    end
    checks++;
    if (o_data !== {16'h0, l0[511:496]}) begin
      errors++;
      $display("FAIL end_offset data: got %h required %h", o_data, {16'h0, l0[511:496]});
    end
  endtask

  task automatic test_multi_hit();
    exp_t e, g;
    logic [LB-1:0] l0, l3;
    @(negedge clk);
    random_lines();
    distinct_tags();
    i_way_tags[0*TB +: TB] = 18'h1F0F;
    i_way_tags[3*TB +: TB] = 18'h1F0F;
    i_tag = 18'h1F0F;
    i_way_valid = 4'b1111;
    i_offset = 6'd17;
    l0 = i_way_lines[0*LB +: LB];
    l3 = i_way_lines[3*LB +: LB];
    push_lookup();
    @(negedge clk);
    i_lookup = 1'b0;
    e = exp_q.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL multi_hit result: got mask=%b way=%0d multi=%b data=%h required mask=%b way=%0d multi=%b data=%h",
               g.mask, g.way, g.multi, g.data, e.mask, e.way, e.multi, e.data);
    end
    checks++;
    if (o_hit_way !== 2'd3 || o_hit_mask !== 4'b1001) begin
      errors++;
      $display("FAIL multi_hit way: got way=%0d mask=%b required way=3 mask=1001", o_hit_way, o_hit_mask);
    end
    checks++;
    if (o_line !== (l0 | l3)) begin
      errors++;
      $display("FAIL multi_hit line: got %h required %h", o_line, l0 | l3);
    end
    checks++;
`ifdef SA_WAY_HIT_SELECT_MULTIHIT_CHECK_EN
    if (o_multi_hit !== 1'b1) begin
      errors++;
      $display("FAIL multi_hit flag: got %b required 1", o_multi_hit);
    end
`else
    if (o_multi_hit !== 1'b0) begin
      errors++;
      $display("FAIL multi_hit flag: got %b required 0", o_multi_hit);
    end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e, g, held;
    @(negedge clk);
    random_lines();
    distinct_tags();
    i_way_tags[2*TB +: TB] = 18'h155;
    i_way_tags[1*TB +: TB] = 18'h2AA;
    i_way_valid = 4'b1111;
    i_tag = 18'h155;
    i_offset = 6'd0;
    push_lookup();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b first valid: got %b required 1", o_valid);
    end
    e = exp_q.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL b2b first result: got mask=%b way=%0d data=%h required mask=%b way=%0d data=%h",
               g.mask, g.way, g.data, e.mask, e.way, e.data);
    end
    i_tag = 18'h2AA;
    i_offset = 6'd10;
    push_lookup();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b second valid: got %b required 1", o_valid);
    end
    held = exp_q.pop_front();
    g = observed();
    checks++;
    if (g !== held) begin
      errors++;
      $display("FAIL b2b second result: got mask=%b way=%0d data=%h required mask=%b way=%0d data=%h",
               g.mask, g.way, g.data, held.mask, held.way, held.data);
    end
    i_lookup = 1'b0;
    for (int c = 0; c < 3; c++) begin
      random_lines();
      i_way_tags[0 +: TB] = 18'h2AA;
      i_way_valid = 4'(c + 5);
      i_tag = 18'h2AA;
      i_offset = 6'(c * 7);
      @(negedge clk);
      g = observed();
      checks++;
      if (o_valid !== 1'b0 || g !== held) begin
        errors++;
        $display("FAIL hold cycle %0d: got valid=%b mask=%b way=%0d data=%h required valid=0 mask=%b way=%0d data=%h",
                 c, o_valid, g.mask, g.way, g.data, held.mask, held.way, held.data);
      end
    end
  endtask

  task automatic test_random();
    exp_t e, g, last;
    logic [TB-1:0] pool [3];
    logic prev_lookup;
    pool[0] = 18'h155;
    pool[1] = 18'h2AA;
    pool[2] = 18'h0F0;
    last = observed();
    prev_lookup = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      g = observed();
      checks++;
      if (o_valid !== prev_lookup) begin
        errors++;
        $display("FAIL random valid cycle %0d: got %b required %b", c, o_valid, prev_lookup);
      end else if (o_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random scoreboard cycle %0d: got unexpected result required none", c);
        end else begin
          last = exp_q.pop_front();
          checks++;
          if (g !== last) begin
            errors++;
            $display("FAIL random result cycle %0d: got hit=%b mask=%b way=%0d multi=%b data=%h required hit=%b mask=%b way=%0d multi=%b data=%h",
                     c, g.hit, g.mask, g.way, g.multi, g.data, last.hit, last.mask, last.way, last.multi, last.data);
          end
        end
      end else begin
        checks++;
        if (g !== last) begin
          errors++;
          $display("FAIL random hold cycle %0d: got mask=%b data=%h required mask=%b data=%h",
                   c, g.mask, g.data, last.mask, last.data);
        end
      end
      if (c == 40) break;
      random_lines();
      for (int w = 0; w < W; w++) i_way_tags[w*TB +: TB] = pool[$urandom_range(2)];
      i_tag = pool[$urandom_range(2)];
      i_way_valid = 4'($urandom());
      i_offset = 6'($urandom());
      if ($urandom_range(3) != 0) push_lookup();
      else i_lookup = 1'b0;
      prev_lookup = i_lookup;
    end
    i_lookup = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random drain: got %0d pending results required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_invalid_match();
    test_end_offset();
    test_multi_hit();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_way_hit_select.md
# sa_way_hit_select

Tag-match and way-select datapath for the 4-way set-associative cache. Compares a lookup tag against the stored tags of all ways of one indexed set and qualifies each match with that way's valid bit. Selects the matching line through a one-hot AND-OR mux and extracts the addressed data word. Sits between the cache tag/data arrays and the cache control FSM; it holds no storage beyond its output register stage.

## Interface
- WAYS, 4, number of ways; power of two, at least 2
- TAG_BITS, 18, tag width
- LINE_SIZE_BYTES, 64, cache line size in bytes
- OFFSET_BITS, 6, byte-offset width; equals log2(LINE_SIZE_BYTES)
- DATA_WIDTH, 32, extracted word width; multiple of 8
- Derived, not overridable: LINE_SIZE_BITS = 8*LINE_SIZE_BYTES, WAY_IDX_BITS = $clog2(WAYS)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- i_lookup  in  1  lookup strobe; inputs sampled when high
- i_tag  in  TAG_BITS  lookup tag
- i_offset  in  OFFSET_BITS  byte offset within the line
- i_way_tags  in  WAYS*TAG_BITS  stored tags; way w at [w*TAG_BITS +: TAG_BITS]
- i_way_valid  in  WAYS  valid bit per way
- i_way_lines  in  WAYS*LINE_SIZE_BITS  line data; way w at [w*LINE_SIZE_BITS +: LINE_SIZE_BITS]
- o_valid  out  1  result strobe
- o_hit  out  1  at least one way matched
- o_hit_mask  out  WAYS  per-way qualified match
- o_hit_way  out  WAY_IDX_BITS  encoded hit way
- o_line  out  LINE_SIZE_BITS  selected line
- o_data  out  DATA_WIDTH  word extracted from o_line
- o_multi_hit  out  1  more than one way matched

## Operation
- Per-way raw match: raw[w] = (i_way_tags slice w == i_tag).
- Per-way qualified match: hit[w] = raw[w] & i_way_valid[w].
- Line select: sel_line = OR over w of ({LINE_SIZE_BITS{hit[w]}} & line[w]).
- No hit gives an all-zero line. A multi-hit gives the bitwise OR of the matching lines; this is intentional and is not masked.
- Way encode: o_hit_way is the highest index w with hit[w] = 1, and 0 when there is no hit.
- Word extract: o_data = sel_line[8*i_offset +: DATA_WIDTH].
- Offsets are byte-granular and have no alignment requirement.
- Bytes that fall past the end of the line read as 0. Example: offset 62 with DATA_WIDTH 32 returns {16'h0, line[511:496]}.
- o_hit = |hit.
- o_multi_hit = 1 when popcount(hit) > 1; see Configuration.

## Timing
- Single register stage with a latency of 1 cycle: a lookup sampled at edge N produces its outputs after edge N.
- o_valid is i_lookup registered: exactly one cycle high per accepted lookup. Back-to-back lookups give back-to-back results.
- o_hit, o_hit_mask, o_hit_way, o_line, o_data and o_multi_hit load only when i_lookup = 1. Otherwise they hold their previous values.
- There is no backpressure and no handshake beyond the strobe.
- Reset: on a rising edge with rst = 1, every output goes to 0.
- rst has priority over i_lookup. A lookup presented in the same cycle as rst is discarded: o_valid = 0 on the following cycle.
- Input changes while i_lookup = 0 have no effect on the outputs.

## Configuration
- Macro: SA_WAY_HIT_SELECT_MULTIHIT_CHECK_EN.
- Defined: the popcount detector is built, and o_multi_hit is registered as described in Operation.
- Undefined: the detector is not built, and o_multi_hit is tied to 0.
- All other behaviour is identical with or without the macro.

## Structure
- Package sa_cache_pkg holds:
  - default parameter constants: WAYS, TAG_BITS, LINE_SIZE_BYTES, OFFSET_BITS, DATA_WIDTH
  - derived constants: LINE_SIZE_BITS, WAY_IDX_BITS
  - a function that encodes a hit mask to the highest-index way
- One sub-module, sa_tag_match, instantiated once per way in a generate loop.
  - Ports: tag A, tag B and valid in; qualified match out.
  - Implements the equality compare ANDed with valid.
- The AND-OR line mux, encoder, word extractor and output registers live in the top level.

## Test plan
- Reset: hold rst 2 cycles with i_lookup = 1 -> all outputs 0, o_valid stays 0.
- Single hit, word read: way 2 tag 18'h155 valid, lines[2] = byte k holds value k, i_tag = 18'h155, i_offset = 4, one lookup -> next cycle o_valid = 1, o_hit = 1, o_hit_mask = 4'b0100, o_hit_way = 2, o_data = 32'h07060504.
- Tag matches but invalid: way 1 tag matches, i_way_valid = 4'b1101 with no other match -> o_hit = 0, o_hit_mask = 0, o_hit_way = 0, o_line = 0, o_data = 0.
- End-of-line offset: hit on way 0 with i_offset = 62 -> o_data = {16'h0, line0[511:496]}.
- Multi-hit: ways 0 and 3 both match and are valid -> o_hit_way = 3, o_line = line0 | line3, o_multi_hit = 1 with the macro defined and 0 without it.
- Hold and back-to-back: lookups on cycles 1 and 2 with different tags, then i_lookup = 0 while the inputs change -> o_valid is high on cycles 2 and 3, and the outputs keep the cycle-2 lookup's result afterwards.
